// File: rtl/sub_nbit_serial.sv
// Bit-serial unsigned subtractor Diff = A - B, LSB first, one borrow flop reused per cycle.
// Latency WIDTH cycles accept-to-done; start is ignored while busy, results held until next completion.
module sub_nbit_serial #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic bit_a, bit_b, d_bit, br_next, accept;

    assign bit_a   = a_q[0];
    assign bit_b   = b_q[0];
    assign d_bit   = bit_a ^ bit_b ^ br_q;
    assign br_next = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br_q);
    // A new operation may start from IDLE or straight out of the done cycle.
    assign accept  = start && (state_q != RUN);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        diff_d  = diff_q;
        br_d    = br_q;
        bout_d  = bout_q;
        cnt_d   = cnt_q;

        if (accept) begin
            a_d     = A;
            b_d     = B;
            br_d    = 1'b0;
            cnt_d   = '0;
            state_d = RUN;
        end else begin
            case (state_q)
                RUN: begin
                    a_d   = a_q >> 1;
                    b_d   = b_q >> 1;
                    res_d = {d_bit, res_q[WIDTH-1:1]};
                    br_d  = br_next;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        diff_d  = {d_bit, res_q[WIDTH-1:1]};
                        bout_d  = br_next;
                        state_d = DONE;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign Diff = diff_q;
    assign Bout = bout_q;

endmodule

// File: tb/tb_sub_nbit_serial.sv
// Directed and random checks of the bit-serial subtractor at WIDTH 8, 32 and 2.
module tb_sub_nbit_serial;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0, diff8;
    logic       busy8, done8, bout8;

    logic        start32 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0, diff32;
    logic        busy32, done32, bout32;

    logic       start2 = 1'b0;
    logic [1:0] a2 = '0, b2 = '0, diff2;
    logic       busy2, done2, bout2;

    sub_nbit_serial #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .A(a8), .B(b8),
        .busy(busy8), .done(done8), .Diff(diff8), .Bout(bout8)
    );
    sub_nbit_serial #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .A(a32), .B(b32),
        .busy(busy32), .done(done32), .Diff(diff32), .Bout(bout32)
    );
    sub_nbit_serial #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .A(a2), .B(b2),
        .busy(busy2), .done(done2), .Diff(diff2), .Bout(bout2)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] diff;
        logic       bout;
        bit         glitch;
    } vec_t;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] prev_diff = '0;
    logic       prev_bout = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Caller is at a negedge; drives one op on dut8 and checks timing and result.
    task automatic run8(input vec_t v);
        int got = 0;
        int busy_n = 0;
        bit extra = 0;
        start8 = 1'b1;
        a8 = v.a;
        b8 = v.b;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            check("busy_done_excl", {63'd0, busy8 & done8}, 64'd0);
            if (busy8) begin
                busy_n++;
                check("diff_hold", {56'd0, diff8}, {56'd0, prev_diff});
                check("bout_hold", {63'd0, bout8}, {63'd0, prev_bout});
            end
            if (done8) begin
                got = i;
                break;
            end
            if (i == 1) start8 = 1'b0;
            if (v.glitch && i == 3) begin
                start8 = 1'b1;
                a8 = 8'h00;
                b8 = 8'h01;
            end else begin
                if (v.glitch && i == 4) start8 = 1'b0;
                a8 = 8'($urandom);
                b8 = 8'($urandom);
            end
        end
        check("done_seen", {63'd0, got != 0}, 64'd1);
        check("latency", 64'(got - 1), 64'd8);
        check("busy_cycles", 64'(busy_n), 64'd8);
        check("diff", {56'd0, diff8}, {56'd0, v.diff});
        check("bout", {63'd0, bout8}, {63'd0, v.bout});
        prev_diff = v.diff;
        prev_bout = v.bout;
        @(negedge clk);
        check("done_one_cycle", {62'd0, busy8, done8}, 64'd0);
        if (v.glitch) begin
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (done8) extra = 1;
            end
            check("ignored_start_no_done", {63'd0, extra}, 64'd0);
        end
    endtask

    initial begin
        vec_t vecs[8];
        int   got;
        bit   seen;
        logic [32:0] exp33;
        logic [2:0]  exp3;

        vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
        vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[3] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b0};
        vecs[4] = '{8'h00, 8'hFF, 8'h01, 1'b1, 1'b0};
        vecs[5] = '{8'h10, 8'h01, 8'h0F, 1'b0, 1'b1};
        vecs[6] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
        vecs[7] = '{8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        check("rst_busy", {63'd0, busy8}, 64'd0);
        check("rst_done", {63'd0, done8}, 64'd0);
        check("rst_diff", {56'd0, diff8}, 64'd0);
        check("rst_bout", {63'd0, bout8}, 64'd0);

        // Release reset and request start in the same step: first edge must accept.
        rst_n = 1'b1;
        foreach (vecs[i]) run8(vecs[i]);

        // Start held high across two ops: done pulses WIDTH+1 apart.
        start8 = 1'b1;
        a8 = 8'd9;
        b8 = 8'd4;
        got = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (done8) begin got = i; break; end
            if (i == 1) begin a8 = 8'd4; b8 = 8'd9; end
        end
        check("b2b_first_latency", 64'(got), 64'd9);
        check("b2b_first_diff", {56'd0, diff8}, 64'h05);
        check("b2b_first_bout", {63'd0, bout8}, 64'd0);
        got = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            check("b2b_excl", {63'd0, busy8 & done8}, 64'd0);
            if (done8) begin got = i; break; end
            if (i == 1) start8 = 1'b0;
        end
        check("b2b_gap", 64'(got), 64'd9);
        check("b2b_second_diff", {56'd0, diff8}, 64'hFB);
        check("b2b_second_bout", {63'd0, bout8}, 64'd1);
        prev_diff = 8'hFB;
        prev_bout = 1'b1;
        @(negedge clk);

        // Reset in the middle of RUN.
        start8 = 1'b1;
        a8 = 8'h33;
        b8 = 8'h11;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i == 1) start8 = 1'b0;
        end
        check("pre_rst_busy", {63'd0, busy8}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", {63'd0, busy8}, 64'd0);
        check("midrst_done", {63'd0, done8}, 64'd0);
        check("midrst_diff", {56'd0, diff8}, 64'd0);
        check("midrst_bout", {63'd0, bout8}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        prev_diff = '0;
        prev_bout = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done8 || busy8) seen = 1;
        end
        check("midrst_no_done", {63'd0, seen}, 64'd0);
        run8('{8'h33, 8'h11, 8'h22, 1'b0, 1'b0});

        // Random regression, WIDTH=32.
        for (int n = 0; n < 20; n++) begin
            start32 = 1'b1;
            a32 = $urandom;
            b32 = $urandom;
            exp33 = {1'b0, a32} - {1'b0, b32};
            got = 0;
            for (int i = 1; i <= 40; i++) begin
                @(negedge clk);
                if (i == 1) start32 = 1'b0;
                if (done32) begin got = i; break; end
            end
            check("w32_latency", 64'(got), 64'd33);
            check("w32_result", {31'd0, bout32, diff32}, {31'd0, exp33});
            @(negedge clk);
        end

        // Random regression, WIDTH=2.
        for (int n = 0; n < 20; n++) begin
            start2 = 1'b1;
            a2 = 2'($urandom_range(3));
            b2 = 2'($urandom_range(3));
            exp3 = {1'b0, a2} - {1'b0, b2};
            got = 0;
            for (int i = 1; i <= 10; i++) begin
                @(negedge clk);
                if (i == 1) start2 = 1'b0;
                if (done2) begin got = i; break; end
            end
            check("w2_latency", 64'(got), 64'd3);
            check("w2_result", {61'd0, bout2, diff2}, {61'd0, exp3});
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
